// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the adder tree and its input gather stage.
package adder_tree_pkg;

  localparam int unsigned ADDER_WIDTH = 12;
  localparam int unsigned LEAF_COUNT  = 8;
  localparam int unsigned LANE_IDX_W  = $clog2(LEAF_COUNT);

  typedef logic [ADDER_WIDTH-1:0] sample_t;
  typedef logic [LANE_IDX_W-1:0]  lane_idx_t;

endpackage

// File: rtl/gather_bank.sv
// One LANES x WIDTH gather bank: lane-indexed write, full flag and, with
// GATHER_FLUSH_EN, tail-zero clear plus a partial flag.
module gather_bank
  import adder_tree_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH,
  parameter int unsigned LANES = LEAF_COUNT,
  localparam int unsigned IDX_W = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   set_full,
  input  logic                   clr_full,
`ifdef GATHER_FLUSH_EN
  input  logic                   tail_clr,
  input  logic                   set_partial,
  output logic                   partial,
`endif
  output logic                   full,
  output logic [LANES*WIDTH-1:0] lanes
);

  logic [LANES-1:0][WIDTH-1:0] lanes_q, lanes_d;
  logic                        full_q, full_d;

  // Tail clear runs first so a coincident write at wr_idx survives it.
  always_comb begin
    lanes_d = lanes_q;
`ifdef GATHER_FLUSH_EN
    if (tail_clr) begin
      for (int k = 0; k < int'(LANES); k++) begin
        if (k >= int'(wr_idx)) lanes_d[k] = '0;
      end
    end
`endif
    if (wr_en) lanes_d[wr_idx] = wr_data;
    full_d = full_q;
    if (clr_full) full_d = 1'b0;
    if (set_full) full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q <= '0;
      full_q  <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      full_q  <= full_d;
    end
  end

`ifdef GATHER_FLUSH_EN
  logic partial_q, partial_d;

  always_comb begin
    partial_d = partial_q;
    if (clr_full) partial_d = 1'b0;
    if (set_full) partial_d = set_partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) partial_q <= 1'b0;
    else        partial_q <= partial_d;
  end

  assign partial = partial_q;
`endif

  assign full  = full_q;
  assign lanes = lanes_q;

endmodule

// File: rtl/adder_tree_gather.sv
// Ping-pong gather of a sample stream into LANES-wide vectors for the adder
// tree leaves. Optional flush of partial vectors under GATHER_FLUSH_EN.
module adder_tree_gather
  import adder_tree_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH,
  parameter int unsigned LANES = LEAF_COUNT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef GATHER_FLUSH_EN
  input  logic                   flush,
  output logic                   out_partial,
`endif
  output logic [LANES*WIDTH-1:0] out_lanes
);

  localparam int unsigned IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wb_q, wb_d;
  logic             rb_q, rb_d;

  logic [1:0]                  bank_full;
  logic [1:0][LANES*WIDTH-1:0] bank_lanes;

  logic accept_c, last_c, flush_c, close_c, drain_c;

  // Handshake decode uses registered state only.
  assign in_ready  = ~bank_full[wb_q];
  assign out_valid = bank_full[rb_q];
  assign out_lanes = bank_lanes[rb_q];

  assign accept_c = in_valid & in_ready;
  assign last_c   = accept_c & (idx_q == LAST_IDX);
  assign drain_c  = out_valid & out_ready;

`ifdef GATHER_FLUSH_EN
  logic [1:0] bank_partial;

  // A flush on the lane-filling accept is an ordinary completion.
  assign flush_c     = flush & (idx_q != '0) & ~last_c;
  assign out_partial = bank_partial[rb_q];
`else
  assign flush_c = 1'b0;
`endif

  assign close_c = last_c | flush_c;

  always_comb begin
    idx_d = idx_q;
    wb_d  = wb_q;
    rb_d  = rb_q;
    if (close_c) begin
      idx_d = '0;
      wb_d  = ~wb_q;
    end else if (accept_c) begin
      idx_d = idx_q + IDX_W'(1);
    end
    if (drain_c) rb_d = ~rb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      wb_q  <= 1'b0;
      rb_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      wb_q  <= wb_d;
      rb_q  <= rb_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    gather_bank #(
      .WIDTH (WIDTH),
      .LANES (LANES)
    ) u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (accept_c & (wb_q == 1'(b))),
      .wr_idx      (idx_q),
      .wr_data     (in_data),
      .set_full    (close_c & (wb_q == 1'(b))),
      .clr_full    (drain_c & (rb_q == 1'(b))),
`ifdef GATHER_FLUSH_EN
      .tail_clr    (flush_c & (wb_q == 1'(b))),
      .set_partial (flush_c),
      .partial     (bank_partial[b]),
`endif
      .full        (bank_full[b]),
      .lanes       (bank_lanes[b])
    );
  end

endmodule

// File: tb/tb_adder_tree_gather.sv
// Directed self-checking bench for adder_tree_gather (flush scenarios only
// when built with GATHER_FLUSH_EN).
module tb_adder_tree_gather;

  localparam int W  = 12;
  localparam int L  = 8;
  localparam int LW = W * L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] out_lanes;
  logic          part_w;
`ifdef GATHER_FLUSH_EN
  logic          flush = 1'b0;
  logic          out_partial;
  assign part_w = out_partial;
`else
  assign part_w = 1'b0;
`endif

  int cmps = 0;
  int errs = 0;

  logic [LW-1:0] vq[$];
  logic          pq[$];

  adder_tree_gather dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef GATHER_FLUSH_EN
    .flush      (flush),
    .out_partial(out_partial),
`endif
    .out_lanes  (out_lanes)
  );

  always #5 clk = ~clk;

  // Record every vector handed over on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vq.push_back(out_lanes);
      pq.push_back(part_w);
    end
  end

  function automatic logic [LW-1:0] vec(int base, int step, int n);
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < L; k++)
      if (k < n) v[k*W +: W] = W'(base + step * k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 12'h123;
    tick(); tick();
    cmps++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    cmps++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    cmps++; if (out_lanes !== '0) begin errs++; $display("FAIL reset_out_lanes got %h want 0", out_lanes); end
    cmps++; if (part_w !== 1'b0) begin errs++; $display("FAIL reset_out_partial got %b want 0", part_w); end
    in_valid = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_vector();
    vq.delete(); pq.delete();
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      in_valid = 1'b1; in_data = W'(s + 1);
      if (s == 7) begin
        cmps++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_early_valid got %b want 0", out_valid); end
      end
      tick();
    end
    in_valid = 1'b0;
    cmps++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_latency got %b want 1", out_valid); end
    cmps++; if (out_lanes !== vec(1, 1, 8)) begin errs++; $display("FAIL single_lanes got %h want %h", out_lanes, vec(1, 1, 8)); end
    tick();
    cmps++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_drained got %b want 0", out_valid); end
    cmps++;
    if (vq.size() != 1) begin errs++; $display("FAIL single_count got %0d want 1", vq.size()); end
    else if (vq[0] !== vec(1, 1, 8)) begin errs++; $display("FAIL single_emitted got %h want %h", vq[0], vec(1, 1, 8)); end
  endtask

  task automatic test_stream();
    vq.delete(); pq.delete();
    out_ready = 1'b1;
    for (int s = 0; s < 24; s++) begin
      in_valid = 1'b1; in_data = W'(s + 1);
      cmps++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_in_ready[%0d] got %b want 1", s, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    cmps++;
    if (vq.size() != 3) begin errs++; $display("FAIL stream_count got %0d want 3", vq.size()); end
    else begin
      for (int v = 0; v < 3; v++) begin
        cmps++; if (vq[v] !== vec(1 + 8 * v, 1, 8)) begin errs++; $display("FAIL stream_vec[%0d] got %h want %h", v, vq[v], vec(1 + 8 * v, 1, 8)); end
        cmps++; if (pq[v] !== 1'b0) begin errs++; $display("FAIL stream_partial[%0d] got %b want 0", v, pq[v]); end
      end
    end
  endtask

  task automatic test_back_pressure();
    vq.delete(); pq.delete();
    out_ready = 1'b0;
    for (int s = 0; s < 16; s++) begin
      in_valid = 1'b1; in_data = W'(s + 1);
      cmps++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_in_ready[%0d] got %b want 1", s, in_ready); end
      tick();
    end
    cmps++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    cmps++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
    in_data = 12'd17;
    tick(); tick();
    cmps++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_still_full got %b want 0", in_ready); end
    cmps++; if (out_lanes !== vec(1, 1, 8)) begin errs++; $display("FAIL bp_stable got %h want %h", out_lanes, vec(1, 1, 8)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    cmps++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_back got %b want 1", in_ready); end
    cmps++; if (out_lanes !== vec(9, 1, 8)) begin errs++; $display("FAIL bp_second got %h want %h", out_lanes, vec(9, 1, 8)); end
    out_ready = 1'b1;
    tick();
    for (int s = 0; s < 8; s++) begin
      in_valid = 1'b1; in_data = W'(32 + s);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    out_ready = 1'b0;
    cmps++;
    if (vq.size() != 3) begin errs++; $display("FAIL bp_count got %0d want 3", vq.size()); end
    else begin
      cmps++; if (vq[0] !== vec(1, 1, 8)) begin errs++; $display("FAIL bp_vec0 got %h want %h", vq[0], vec(1, 1, 8)); end
      cmps++; if (vq[1] !== vec(9, 1, 8)) begin errs++; $display("FAIL bp_vec1 got %h want %h", vq[1], vec(9, 1, 8)); end
      cmps++; if (vq[2] !== vec(32, 1, 8)) begin errs++; $display("FAIL bp_no17 got %h want %h", vq[2], vec(32, 1, 8)); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int s = 0; s < 13; s++) begin
      in_valid = 1'b1; in_data = W'(256 + s);
      tick();
    end
    in_valid = 1'b0;
    cmps++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rmid_pending got %b want 1", out_valid); end
    rst_n = 1'b0;
    tick();
    cmps++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    cmps++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready got %b want 1", in_ready); end
    cmps++; if (out_lanes !== '0) begin errs++; $display("FAIL rmid_lanes got %h want 0", out_lanes); end
    rst_n = 1'b1;
    tick();
    vq.delete(); pq.delete();
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      in_valid = 1'b1; in_data = W'(12'hA00 + s);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    cmps++;
    if (vq.size() != 1) begin errs++; $display("FAIL rmid_count got %0d want 1", vq.size()); end
    else if (vq[0] !== vec(12'hA00, 1, 8)) begin errs++; $display("FAIL rmid_vec got %h want %h", vq[0], vec(12'hA00, 1, 8)); end
  endtask

`ifdef GATHER_FLUSH_EN
  task automatic test_flush_partial();
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      in_valid = 1'b1; in_data = 12'h555;
      tick();
    end
    in_valid = 1'b0;
    tick();
    vq.delete(); pq.delete();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1'b1; in_data = 12'hFFF;
      tick();
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    cmps++; if (out_valid !== 1'b1) begin errs++; $display("FAIL flush_valid got %b want 1", out_valid); end
    cmps++; if (out_partial !== 1'b1) begin errs++; $display("FAIL flush_partial got %b want 1", out_partial); end
    cmps++; if (out_lanes !== vec(12'hFFF, 0, 3)) begin errs++; $display("FAIL flush_lanes got %h want %h", out_lanes, vec(12'hFFF, 0, 3)); end
    cmps++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    cmps++; if (out_partial !== 1'b0) begin errs++; $display("FAIL flush_partial_after got %b want 0", out_partial); end
    cmps++;
    if (vq.size() != 1) begin errs++; $display("FAIL flush_count got %0d want 1", vq.size()); end
    else if (pq[0] !== 1'b1) begin errs++; $display("FAIL flush_emitted_partial got %b want 1", pq[0]); end
  endtask

  task automatic test_flush_edges();
    vq.delete(); pq.delete();
    out_ready = 1'b1;
    flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    cmps++; if (out_valid !== 1'b0) begin errs++; $display("FAIL fidle_valid got %b want 0", out_valid); end
    for (int s = 0; s < 8; s++) begin
      in_valid = 1'b1; in_data = W'(48 + s);
      flush = (s == 7);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
    cmps++; if (out_partial !== 1'b0) begin errs++; $display("FAIL flast_partial got %b want 0", out_partial); end
    tick(); tick();
    cmps++;
    if (vq.size() != 1) begin errs++; $display("FAIL flast_count got %0d want 1", vq.size()); end
    else begin
      cmps++; if (vq[0] !== vec(48, 1, 8)) begin errs++; $display("FAIL flast_vec got %h want %h", vq[0], vec(48, 1, 8)); end
      cmps++; if (pq[0] !== 1'b0) begin errs++; $display("FAIL flast_emitted_partial got %b want 0", pq[0]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_vector();
    test_stream();
    test_back_pressure();
    test_reset_mid();
`ifdef GATHER_FLUSH_EN
    test_flush_partial();
    test_flush_edges();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/adder_tree_gather.md
ADDER_TREE_GATHER -- requirements
Module: adder_tree_gather

Interface
REQ-001 Parameter WIDTH, default 12: sample width in bits, equal to the tree leaf width.
REQ-002 Parameter LANES, default 8: samples per output vector, equal to the tree leaf count; power of two, at least 2.
REQ-003 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  upstream sample valid.
REQ-006 in_ready  out  1  block can accept a sample this cycle.
REQ-007 in_data  in  WIDTH  sample value, unsigned.
REQ-008 out_valid  out  1  a complete vector is presented to the tree input registers.
REQ-009 out_ready  in  1  tree stage consumes the vector this cycle.
REQ-010 out_lanes  out  LANES*WIDTH  vector; lane k occupies bits [k*WIDTH +: WIDTH] and maps to tree leaf k in leaf-index order (leaf 0_0_0_0 = lane 0).
REQ-011 flush  in  1  present only with GATHER_FLUSH_EN; closes a partial vector.
REQ-012 out_partial  out  1  present only with GATHER_FLUSH_EN; the presented vector was closed by flush.

Function
REQ-013 The block SHALL hold two register banks (ping-pong) of LANES x WIDTH each, plus a full flag per bank, a write-bank pointer wb, a read-bank pointer rb and a lane index idx of log2(LANES) bits.
REQ-014 A sample SHALL be accepted exactly when in_valid and in_ready are both 1; it is written to lane idx of bank wb.
REQ-015 idx SHALL increment on each accept; on the accept at idx = LANES-1, idx wraps to 0, full[wb] is set and wb toggles in the same edge.
REQ-016 in_ready SHALL equal NOT full[wb], decoded from registers only, with no combinational path from in_valid or out_ready.
REQ-017 out_valid SHALL equal full[rb], and out_lanes SHALL equal bank rb.
REQ-018 On out_valid and out_ready both 1, full[rb] SHALL clear and rb toggles; bank contents are not cleared.
REQ-019 Latency: out_valid SHALL rise on the edge following the accept of the last lane, which is one cycle after that accept.
REQ-020 Throughput: with out_ready held at 1, the block SHALL accept one sample per cycle indefinitely with in_ready never dropping.
REQ-021 A bank completing and the other bank draining on the same edge SHALL both take effect; no sample or vector is lost or duplicated.
REQ-022 With both banks full, in_ready SHALL be 0 and in_data SHALL be ignored; out_lanes SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-023 No arithmetic is performed and sample values pass unmodified; the tree supplies the log2(LANES) growth bits.

Reset
REQ-024 While rst_n = 0, the block SHALL force idx = 0, wb = 0, rb = 0, both full flags = 0 and all bank bits = 0, giving out_valid = 0, out_lanes = 0, in_ready = 1 and out_partial = 0.
REQ-025 Reset asserted mid-vector SHALL discard any partial and any pending vectors without emitting them.
REQ-026 The first accept after rst_n deasserts SHALL be written to lane 0 of bank 0.

Configuration
REQ-027 Macro GATHER_FLUSH_EN SHALL compile in the flush input, the out_partial output and one partial flag per bank.
REQ-028 With the macro, flush = 1 while idx > 0 SHALL zero lanes idx..LANES-1 of bank wb, set full[wb] and its partial flag, toggle wb and reset idx to 0.
REQ-029 If flush coincides with an accept, the sample SHALL be written first; if that sample fills lane LANES-1, the edge is a normal completion with the partial flag at 0.
REQ-030 flush with idx = 0 SHALL be ignored.
REQ-031 out_partial SHALL equal the partial flag of bank rb.
REQ-032 Without the macro, the ports and flags SHALL be absent and behaviour is REQ-013 to REQ-026 only.

Structure
REQ-033 Shared package adder_tree_pkg SHALL hold the ADDER_WIDTH and LEAF_COUNT constants, a sample_t typedef (logic [ADDER_WIDTH-1:0]) and a lane-index typedef; parameter defaults derive from these.
REQ-034 One sub-module, gather_bank, SHALL implement one LANES x WIDTH bank with lane-indexed write, tail-zero clear and a full/partial flag; it is instantiated twice.

Verification
REQ-035 Feed samples 1..8 back-to-back with out_ready = 1: out_valid rises one cycle after sample 8, and out_lanes lane k = k+1.
REQ-036 Feed 24 samples continuously with out_ready = 1: in_ready stays 1, three vectors are emitted (1..8, 9..16, 17..24) and out_partial = 0.
REQ-037 Hold out_ready = 0 and feed 16 samples: in_ready = 0 after the 16th accept and sample 17 is not taken; one out_ready pulse emits 1..8 and in_ready returns to 1 the next cycle.
REQ-038 Assert rst_n = 0 after 5 samples, then feed 8 samples of 0xA00..0xA07: a single vector with lane 0 = 0xA00 is emitted, with no residue from before reset.
REQ-039 With GATHER_FLUSH_EN, feed 3 samples 0xFFF and pulse flush: vector = 0xFFF in lanes 0..2 and 0 in lanes 3..7, with out_partial = 1.
REQ-040 With GATHER_FLUSH_EN, flush at idx = 0, and flush together with the 8th sample: no extra vector is emitted, and the completed vector has out_partial = 0.
